// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between GPU (port 0),
// CPU (port 1) and the SD-card loader (port 2). One transaction is in flight at a
// time. GPU has priority up to MAX_GPU_RUN consecutive grants while another port
// waits; CPU and SD share a round-robin slot.
module sdram_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int MAX_GPU_RUN = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ctrl_req,
  output logic                  ctrl_we,
  output logic [ADDR_W-1:0]     ctrl_addr,
  output logic [DATA_W-1:0]     ctrl_wdata,
  input  logic                  ctrl_ready,
  input  logic [DATA_W-1:0]     ctrl_rdata,
  input  logic                  ctrl_rvalid
);

  localparam int RUN_W = $clog2(MAX_GPU_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_GPU_RUN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       grant;
  logic [1:0]       rr_last;
  logic [RUN_W-1:0] gpu_run;
  logic [1:0]       win;
  logic             others;
  logic             gpu_ok;

  // Saturating increment of the GPU run length.
  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + 1'b1;
  endfunction

  // One-hot completion pulse for the granted port.
  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    return 3'b001 << p;
  endfunction

  // Pick the winner among the current requests: bounded GPU priority, then CPU/SD round-robin.
  always_comb begin
    others = req[1] | req[2];
    gpu_ok = req[0] && ((gpu_run < RUN_MAX) || !others);
    win    = 2'd0;
    if (gpu_ok)                win = 2'd0;
    else if (req[1] && req[2]) win = (rr_last == 2'd1) ? 2'd2 : 2'd1;
    else if (req[1])           win = 2'd1;
    else if (req[2])           win = 2'd2;
  end

  // Transaction FSM: latch the winner's command, hand it to the controller, pulse ack on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 2'd0;
      ack        <= 3'b000;
      rdata      <= '0;
      ctrl_req   <= 1'b0;
      ctrl_we    <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      rr_last    <= 2'd1;
      gpu_run    <= '0;
    end else begin
      ack <= 3'b000;
      case (state)
        IDLE: begin
          // No grant while an ack is showing: the acked requester is dropping its req this cycle.
          if (ack == 3'b000 && req != 3'b000) begin
            grant      <= win;
            ctrl_req   <= 1'b1;
            ctrl_we    <= req_we[win];
            ctrl_addr  <= req_addr[32'(win)*ADDR_W +: ADDR_W];
            ctrl_wdata <= req_wdata[32'(win)*DATA_W +: DATA_W];
            if (win == 2'd0) begin
              gpu_run <= others ? sat_inc(gpu_run) : '0;
            end else begin
              gpu_run <= '0;
              rr_last <= win;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ctrl_ready) begin
            ctrl_req <= 1'b0;
            if (ctrl_we) begin
              ack   <= port_onehot(grant);
              state <= IDLE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (ctrl_rvalid) begin
            rdata <= ctrl_rdata;
            ack   <= port_onehot(grant);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
